// File: rtl/toggle_decoder_if.sv
// toggle_decoder_if: sample input, clear and decoded-toggle outputs of toggle_decoder
interface toggle_decoder_if #(
    parameter int CNT_W = 16,
    parameter int RUN_W = 8
);
    logic             clr;
    logic             in_valid;
    logic             in_q;
    logic             t_valid;
    logic             t_out;
    logic             locked;
    logic [CNT_W-1:0] toggle_cnt;
    logic [RUN_W-1:0] run_len;
    logic [RUN_W-1:0] max_run;

    modport master (
        output clr, in_valid, in_q,
        input  t_valid, t_out, locked, toggle_cnt, run_len, max_run
    );

    modport slave (
        input  clr, in_valid, in_q,
        output t_valid, t_out, locked, toggle_cnt, run_len, max_run
    );
endinterface

// File: rtl/toggle_decoder.sv
// toggle_decoder: recovers t = q ^ previous q from a sampled q stream and keeps toggle statistics
module toggle_decoder #(
    parameter int CNT_W = 16,
    parameter int RUN_W = 8
) (
    input logic            clk,
    input logic            rst,
    toggle_decoder_if.slave bus
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state_q, state_d;
    logic             q_prev_q, q_prev_d;
    logic             t_valid_q, t_valid_d;
    logic             t_out_q, t_out_d;
    logic [CNT_W-1:0] toggle_cnt_q, toggle_cnt_d;
    logic [RUN_W-1:0] run_len_q, run_len_d;
    logic [RUN_W-1:0] max_run_q, max_run_d;
    logic             t;

    assign t = bus.in_q ^ q_prev_q;

    // next state: clr drops everything; first sample only primes q_prev, later ones decode
    always_comb begin
        state_d      = state_q;
        q_prev_d     = q_prev_q;
        t_valid_d    = 1'b0;
        t_out_d      = t_out_q;
        toggle_cnt_d = toggle_cnt_q;
        run_len_d    = run_len_q;
        max_run_d    = max_run_q;
        if (bus.clr) begin
            state_d      = IDLE;
            q_prev_d     = 1'b0;
            t_out_d      = 1'b0;
            toggle_cnt_d = '0;
            run_len_d    = '0;
            max_run_d    = '0;
        end else if (bus.in_valid) begin
            q_prev_d = bus.in_q;
            if (state_q == IDLE) begin
                state_d = LOCKED;
            end else begin
                t_valid_d    = 1'b1;
                t_out_d      = t;
                toggle_cnt_d = t ? ((&toggle_cnt_q) ? toggle_cnt_q : toggle_cnt_q + 1'b1) : toggle_cnt_q;
                run_len_d    = t ? '0 : ((&run_len_q) ? run_len_q : run_len_q + 1'b1);
                max_run_d    = (run_len_d > max_run_q) ? run_len_d : max_run_q;
            end
        end
    end

    // state and statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            q_prev_q     <= 1'b0;
            t_valid_q    <= 1'b0;
            t_out_q      <= 1'b0;
            toggle_cnt_q <= '0;
            run_len_q    <= '0;
            max_run_q    <= '0;
        end else begin
            state_q      <= state_d;
            q_prev_q     <= q_prev_d;
            t_valid_q    <= t_valid_d;
            t_out_q      <= t_out_d;
            toggle_cnt_q <= toggle_cnt_d;
            run_len_q    <= run_len_d;
            max_run_q    <= max_run_d;
        end
    end

    assign bus.t_valid    = t_valid_q;
    assign bus.t_out      = t_out_q;
    assign bus.locked     = (state_q == LOCKED);
    assign bus.toggle_cnt = toggle_cnt_q;
    assign bus.run_len    = run_len_q;
    assign bus.max_run    = max_run_q;
endmodule

// File: tb/tb_toggle_decoder.sv
// tb_toggle_decoder: scoreboard bench for toggle_decoder with directed vectors
module tb_toggle_decoder;
    typedef struct {
        logic       t;
        logic       st;
        logic [3:0] cnt;
        logic [7:0] run;
        logic [7:0] mx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passes = 0;
    int   total = 0;
    exp_t sb[$];
    logic tff_q;
    logic lb_t [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    toggle_decoder_if #(.CNT_W(4), .RUN_W(8)) bus ();
    toggle_decoder #(.CNT_W(4), .RUN_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passes++;
    endtask

    task automatic drive(input logic v, input logic q, input logic c);
        bus.in_valid = v;
        bus.in_q     = q;
        bus.clr      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic t, input logic st, input logic [3:0] cnt, input logic [7:0] run, input logic [7:0] mx);
        exp_t e;
        e.t = t; e.st = st; e.cnt = cnt; e.run = run; e.mx = mx;
        sb.push_back(e);
    endtask

    task automatic chk_stats(input string name, input logic [3:0] cnt, input logic [7:0] run, input logic [7:0] mx);
        chk({name, "_cnt"}, 32'(bus.toggle_cnt), 32'(cnt));
        chk({name, "_run"}, 32'(bus.run_len), 32'(run));
        chk({name, "_max"}, 32'(bus.max_run), 32'(mx));
    endtask

    // monitor: every t_valid pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && bus.t_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_t_valid", 32'(bus.t_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("t_out", 32'(bus.t_out), 32'(e.t));
                if (e.st) begin
                    chk("sb_cnt", 32'(bus.toggle_cnt), 32'(e.cnt));
                    chk("sb_run", 32'(bus.run_len), 32'(e.run));
                    chk("sb_max", 32'(bus.max_run), 32'(e.mx));
                end
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_q     = 1'b0;
        bus.clr      = 1'b0;
        // 1: reset with random inputs
        repeat (2) drive(1'($urandom), 1'($urandom), 1'b0);
        chk("rst_t_valid", 32'(bus.t_valid), 32'd0);
        chk("rst_t_out", 32'(bus.t_out), 32'd0);
        chk("rst_locked", 32'(bus.locked), 32'd0);
        chk_stats("rst", 4'd0, 8'd0, 8'd0);
        rst = 1'b0;
        // 2: basic decode of 0,0,1,1,0
        drive(1'b1, 1'b0, 1'b0);
        chk("prime_t_valid", 32'(bus.t_valid), 32'd0);
        chk("prime_locked", 32'(bus.locked), 32'd1);
        push(1'b0, 1'b1, 4'd0, 8'd1, 8'd1); drive(1'b1, 1'b0, 1'b0);
        push(1'b1, 1'b1, 4'd1, 8'd0, 8'd1); drive(1'b1, 1'b1, 1'b0);
        push(1'b0, 1'b1, 4'd1, 8'd1, 8'd1); drive(1'b1, 1'b1, 1'b0);
        push(1'b1, 1'b1, 4'd2, 8'd0, 8'd1); drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        chk("idle_t_valid", 32'(bus.t_valid), 32'd0);
        chk("idle_t_out_hold", 32'(bus.t_out), 32'd1);
        chk_stats("basic", 4'd2, 8'd0, 8'd1);
        // 3: gaps between samples
        drive(1'b0, 1'b0, 1'b1);
        chk("clr_locked", 32'(bus.locked), 32'd0);
        drive(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            chk("gap_t_valid", 32'(bus.t_valid), 32'd0);
        end
        push(1'b1, 1'b1, 4'd1, 8'd0, 8'd0); drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("gap_single_pulse", 32'(bus.t_valid), 32'd0);
        chk_stats("gap", 4'd1, 8'd0, 8'd0);
        // 4: saturation of both counters
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            push(1'b1, 1'b0, 4'd0, 8'd0, 8'd0);
            drive(1'b1, (i % 2 == 0), 1'b0);
        end
        chk_stats("cnt_sat", 4'd15, 8'd0, 8'd0);
        for (int i = 0; i < 300; i++) begin
            push(1'b0, 1'b0, 4'd0, 8'd0, 8'd0);
            drive(1'b1, 1'b0, 1'b0);
            if (i == 254) chk_stats("run_255", 4'd15, 8'd255, 8'd255);
        end
        chk_stats("run_sat", 4'd15, 8'd255, 8'd255);
        // 5: clr mid-stream drops the offered sample
        drive(1'b1, 1'b1, 1'b1);
        chk("clr_mid_locked", 32'(bus.locked), 32'd0);
        chk("clr_mid_t_valid", 32'(bus.t_valid), 32'd0);
        chk_stats("clr_mid", 4'd0, 8'd0, 8'd0);
        drive(1'b1, 1'b0, 1'b0);
        chk("reprime_t_valid", 32'(bus.t_valid), 32'd0);
        push(1'b1, 1'b1, 4'd1, 8'd0, 8'd0); drive(1'b1, 1'b1, 1'b0);
        // 6: loopback through a bench T flip-flop
        drive(1'b0, 1'b0, 1'b1);
        tff_q = 1'b0;
        push(1'b0, 1'b1, 4'd0, 8'd1, 8'd1);
        push(1'b1, 1'b1, 4'd1, 8'd0, 8'd1);
        push(1'b0, 1'b1, 4'd1, 8'd1, 8'd1);
        push(1'b1, 1'b1, 4'd2, 8'd0, 8'd1);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, tff_q, 1'b0);
            tff_q = tff_q ^ lb_t[k];
        end
        drive(1'b0, 1'b0, 1'b0);
        chk_stats("loopback", 4'd2, 8'd0, 8'd1);
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
